// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and helpers for the data-memory responder
// Contents: funct3 codes for load/store width, FSM state encoding,
//           and a legality check for funct3 against the access direction.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Stores have no unsigned variants; loads accept the five RV32I widths.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        if (write)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian byte/half/word lane steering
// Ports:
//   funct3     in  3   access width / extension code
//   addr_lo    in  2   byte offset within the word
//   old_word   in  32  current storage word
//   wdata      in  32  right-aligned store data
//   store_word out 32  old_word with the addressed lanes replaced
//   load_data  out 32  selected lanes, sign- or zero-extended
//   misalign   out 1   half on odd address or word on non-zero offset
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(old_word >> {addr_lo, 3'b000});
        half_sel = 16'(old_word >> {addr_lo[1], 4'b0000});

        store_word = old_word;
        case (funct3[1:0])
            2'b00:   store_word[{addr_lo, 3'b000} +: 8]      = wdata[7:0];
            2'b01:   store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = old_word;
        endcase

        misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data memory behind a request/response handshake
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_write, req_addr[31:0], req_wdata[31:0], req_funct3[2:0]
//   resp_valid/resp_ready, resp_rdata[31:0], resp_err
// One request in flight. The response is registered on the edge LATENCY-1 after
// acceptance, so the requester sees resp_valid on edge N+LATENCY and a continuous
// stream runs at one request per LATENCY+1 cycles.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [1:0]  state;
    logic [3:0]  count;
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_f3;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        op_write;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [2:0]  op_f3;
    logic [IW-1:0] idx;
    logic        in_range;
    logic [31:0] old_word;
    logic [31:0] store_word;
    logic [31:0] load_data;
    logic        misalign;
    logic        err;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_ready && req_valid;

    // With LATENCY=1 the response is formed on the accept edge itself, so the
    // operation is taken straight from the request pins rather than the capture.
    assign enter_resp = (LATENCY == 1) ? accept
                                       : ((state == WAIT) && (count == 4'(LATENCY - 1)));
    assign op_write = (state == IDLE) ? req_write  : cap_write;
    assign op_addr  = (state == IDLE) ? req_addr   : cap_addr;
    assign op_wdata = (state == IDLE) ? req_wdata  : cap_wdata;
    assign op_f3    = (state == IDLE) ? req_funct3 : cap_f3;

    assign idx      = op_addr[IW+1:2];
    assign in_range = (op_addr[31:2] < 30'(DEPTH_WORDS));
    assign old_word = in_range ? mem[idx] : 32'd0;

    dmem_lane_align u_align (
        .funct3     (op_f3),
        .addr_lo    (op_addr[1:0]),
        .old_word   (old_word),
        .wdata      (op_wdata),
        .store_word (store_word),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    assign err = !in_range || misalign || !f3_legal(op_write, op_f3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            cap_write  <= 1'b0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            cap_f3     <= 3'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cap_write <= req_write;
                    cap_addr  <= req_addr;
                    cap_wdata <= req_wdata;
                    cap_f3    <= req_funct3;
                    // The accept edge already counts as the first latency cycle.
                    count     <= 4'd1;
                    state     <= (LATENCY == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    if (enter_resp) begin
                        state <= RESP;
                        count <= 4'd0;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    count      <= 4'd0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                resp_err   <= err;
                resp_rdata <= (err || op_write) ? 32'd0 : load_data;
            end
        end
    end

    // Storage is not reset; the reset term only keeps a write out of an aborted cycle.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && op_write && !err)
            mem[idx] <= store_word;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (LATENCY 2 and 1)
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [32:0] sbq[$];

    logic        req_valid = 0, req_write = 0, resp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [2:0]  req_funct3 = 0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid1 = 0, req_write1 = 0, resp_ready1 = 0;
    logic [31:0] req_addr1 = 0, req_wdata1 = 0;
    logic [2:0]  req_funct31 = 0;
    logic        req_ready1, resp_valid1, resp_err1;
    logic [31:0] resp_rdata1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_funct3(req_funct31),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input logic [31:0] er, input logic ee,
                        input string nm);
        logic [32:0] ex;
        int n;
        int acc;
        sbq.push_back({ee, er});
        @(negedge clk);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        acc = cyc;
        // Scramble the request pins to prove the responder works from its capture.
        req_valid = 0; req_write = ~w; req_addr = ~a; req_wdata = ~d; req_funct3 = ~f3;
        @(negedge clk);
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        total++;
        if (!resp_valid) begin
            bad++; $display("FAIL %s timeout: resp_valid=%b required 1", nm, resp_valid);
            void'(sbq.pop_front());
            return;
        end
        total++;
        if (cyc - acc + 1 !== LAT) begin
            bad++; $display("FAIL %s latency: got %0d required %0d", nm, cyc - acc + 1, LAT);
        end
        ex = sbq.pop_front();
        total++;
        if (resp_rdata !== ex[31:0]) begin
            bad++; $display("FAIL %s rdata: got %h required %h", nm, resp_rdata, ex[31:0]);
        end
        total++;
        if (resp_err !== ex[32]) begin
            bad++; $display("FAIL %s err: got %b required %b", nm, resp_err, ex[32]);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL %s release: resp_valid=%b req_ready=%b required 0/1",
                            nm, resp_valid, req_ready);
        end
        resp_ready = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            bad++; $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                            req_ready, resp_valid, resp_rdata, resp_err);
        end
        reset = 1;
    endtask

    task automatic test_basic();
        xact(1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 0, "sw_10");
        xact(0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 0, "lw_10");
    endtask

    task automatic test_lanes();
        xact(1, 32'h11, 32'h0000007F, F3_B, 32'h0, 0, "sb_11");
        xact(0, 32'h11, 32'h0, F3_B, 32'h0000007F, 0, "lb_11");
        xact(0, 32'h10, 32'h0, F3_W, 32'hDEAD7FEF, 0, "lw_10_after_sb");
        xact(1, 32'h12, 32'hFFFF8001, F3_H, 32'h0, 0, "sh_12");
        xact(0, 32'h12, 32'h0, F3_H, 32'hFFFF8001, 0, "lh_12");
        xact(0, 32'h12, 32'h0, F3_HU, 32'h00008001, 0, "lhu_12");
        xact(0, 32'h10, 32'h0, F3_B, 32'hFFFFFFEF, 0, "lb_10_sign");
        xact(0, 32'h13, 32'h0, F3_BU, 32'h00000080, 0, "lbu_13");
    endtask

    task automatic test_errors();
        xact(0, 32'h13, 32'h0, F3_W, 32'h0, 1, "lw_misaligned");
        xact(1, 32'h11, 32'h0000FFFF, F3_H, 32'h0, 1, "sh_misaligned");
        xact(0, 32'(DEPTH * 4), 32'h0, F3_W, 32'h0, 1, "lw_out_of_range");
        xact(1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'h0, 1, "store_bad_f3");
        xact(0, 32'h10, 32'h0, 3'b011, 32'h0, 1, "load_bad_f3");
        xact(0, 32'h10, 32'h0, F3_W, 32'h80017FEF, 0, "lw_10_unchanged");
        xact(1, 32'(DEPTH * 4 - 4), 32'h0BADCAFE, F3_W, 32'h0, 0, "sw_last_word");
        xact(0, 32'(DEPTH * 4 - 4), 32'h0, F3_W, 32'h0BADCAFE, 0, "lw_last_word");
    endtask

    task automatic test_stall();
        logic [32:0] ex;
        int n;
        sbq.push_back({1'b0, 32'h80017FEF});
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h10; req_funct3 = F3_W;
        @(posedge clk); #1;
        req_valid = 0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        ex = sbq.pop_front();
        for (int k = 0; k < 5; k++) begin
            req_valid = k[0]; req_write = 1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = F3_W;
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== ex[31:0] || resp_err !== ex[32] || req_ready !== 1'b0) begin
                bad++; $display("FAIL stall_hold[%0d]: valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                                k, resp_valid, resp_rdata, resp_err, req_ready, ex[31:0], ex[32]);
            end
            @(negedge clk);
        end
        req_valid = 0;
        resp_ready = 1;
        @(posedge clk); #1;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL stall_release: ready=%b valid=%b required 1/0", req_ready, resp_valid);
        end
        resp_ready = 0;
        xact(0, 32'h10, 32'h0, F3_W, 32'h80017FEF, 0, "lw_after_stall");
    endtask

    task automatic test_reset_abort();
        xact(1, 32'h20, 32'hCAFEF00D, F3_W, 32'h0, 0, "sw_20_prior");
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = F3_W;
        @(posedge clk); #2;
        req_valid = 0;
        reset = 0;
        #1;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            bad++; $display("FAIL reset_abort_state: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                            req_ready, resp_valid, resp_rdata, resp_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
        xact(0, 32'h20, 32'h0, F3_W, 32'hCAFEF00D, 0, "lw_20_after_abort");
    endtask

    task automatic test_back_to_back();
        logic        tw[6];
        logic [31:0] ta[6], td[6], ter[6];
        logic [2:0]  tf[6];
        logic        tee[6];
        logic [32:0] ex;
        int i, got, last;
        logic rdy;
        tw  = '{1, 1, 0, 0, 0, 0};
        ta  = '{32'h40, 32'h44, 32'h40, 32'h46, 32'h44, 32'h48};
        td  = '{32'h11111111, 32'hA5A55A5A, 0, 0, 0, 0};
        tf  = '{F3_W, F3_W, F3_W, F3_H, F3_BU, 3'b011};
        ter = '{0, 0, 32'h11111111, 32'hFFFFA5A5, 32'h0000005A, 0};
        tee = '{0, 0, 0, 0, 0, 1};
        i = 0; got = 0; last = -1;
        resp_ready1 = 1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            if (resp_valid1) begin
                ex = sbq.pop_front();
                total++;
                if (resp_rdata1 !== ex[31:0] || resp_err1 !== ex[32]) begin
                    bad++; $display("FAIL b2b_resp[%0d]: rdata=%h err=%b required %h/%b",
                                    got, resp_rdata1, resp_err1, ex[31:0], ex[32]);
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== 2) begin
                        bad++; $display("FAIL b2b_spacing[%0d]: got %0d cycles required 2", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            if (i < 6) begin
                req_valid1 = 1; req_write1 = tw[i]; req_addr1 = ta[i]; req_wdata1 = td[i]; req_funct31 = tf[i];
            end else begin
                req_valid1 = 0;
            end
            rdy = req_ready1;
            @(posedge clk); #1;
            if (rdy && req_valid1) begin
                sbq.push_back({tee[i], ter[i]});
                i++;
            end
        end
        req_valid1 = 0;
        resp_ready1 = 0;
        total++;
        if (got !== 6) begin
            bad++; $display("FAIL b2b_count: got %0d responses required 6", got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lanes();
        test_errors();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
